frame_buffer_writer: RTL and testbench

Writer side of the 8x8 LED framebuffer consumed by led_matrix_driver. It accepts pixel write and bulk clear/fill commands over a valid/ready interface into a back buffer. On request, it presents the back buffer as the displayed front buffer, but only at a scan-frame boundary, so the display never shows a half-drawn frame. It replaces direct combinational framebuffer hand-off from game logic to the driver.

---
 rtl/frame_buffer_writer_if.sv | 30 +++
 rtl/frame_buffer_writer.sv | 130 +++++++++++++
 tb/tb_frame_buffer_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_writer_if.sv
// Command, swap and framebuffer signals between a pixel writer client and frame_buffer_writer.
// The master side also carries frame_done, which originates in led_matrix_driver.
interface frame_buffer_writer_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = 8
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [1:0]             wr_op;
  logic [2:0]             wr_x;
  logic [2:0]             wr_y;
  logic                   wr_data;
  logic                   swap_req;
  logic                   swap_ack;
  logic                   frame_done;
  logic [ROWS*COLS-1:0]   framebuffer;
  logic [CW-1:0]          frame_count;
  logic                   busy;

  modport master (
    output wr_valid, wr_op, wr_x, wr_y, wr_data, swap_req, frame_done,
    input  wr_ready, swap_ack, framebuffer, frame_count, busy
  );

  modport slave (
    input  wr_valid, wr_op, wr_x, wr_y, wr_data, swap_req, frame_done,
    output wr_ready, swap_ack, framebuffer, frame_count, busy
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Double-buffered LED framebuffer writer: pixel/bulk commands edit the back buffer,
// and a swap request publishes it to the front buffer only on a scan-frame boundary.
module frame_buffer_writer #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = 8
) (
  input  logic                  system_clk,
  input  logic                  rst,
  frame_buffer_writer_if.slave  bus
);
  localparam int NPIX = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    BULK      = 2'b01,
    WAIT_SWAP = 2'b10,
    ACK       = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [NPIX-1:0]   back_q, back_d;
  logic [NPIX-1:0]   fb_q, fb_d;
  logic [CW-1:0]     count_q, count_d;
  logic [RW-1:0]     row_q, row_d;
  logic              fill_q, fill_d;
  logic              accept_s;
  logic [NPIX-1:0]   pix_mask_s;
  logic [NPIX-1:0]   row_mask_s;

  assign bus.wr_ready    = (state_q == IDLE) && !rst;
  assign bus.busy        = (state_q != IDLE);
  assign bus.swap_ack    = (state_q == ACK);
  assign bus.framebuffer = fb_q;
  assign bus.frame_count = count_q;
  assign accept_s        = bus.wr_valid && bus.wr_ready;

  // Out-of-range coordinates produce an empty mask, so the write is accepted but has no effect.
  always_comb begin
    pix_mask_s = '0;
    row_mask_s = '0;
    for (int i = 0; i < NPIX; i++) begin
      if ((int'(bus.wr_x) < COLS) && (int'(bus.wr_y) < ROWS) &&
          (i == int'(bus.wr_y) * COLS + int'(bus.wr_x))) begin
        pix_mask_s[i] = 1'b1;
      end else begin
        pix_mask_s[i] = 1'b0;
      end
      if ((i / COLS) == int'(row_q)) begin
        row_mask_s[i] = 1'b1;
      end else begin
        row_mask_s[i] = 1'b0;
      end
    end
  end

  // Next-state and datapath updates; a command handshake in IDLE takes priority over swap_req.
  always_comb begin
    state_d = state_q;
    back_d  = back_q;
    fb_d    = fb_q;
    count_d = count_q;
    row_d   = row_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (bus.wr_op)
            2'b00: back_d = (back_q & ~pix_mask_s) | (pix_mask_s & {NPIX{bus.wr_data}});
            2'b01: back_d = back_q ^ pix_mask_s;
            2'b10, 2'b11: begin
              fill_d  = bus.wr_op[0];
              row_d   = '0;
              state_d = BULK;
            end
            default: back_d = back_q;
          endcase
        end else if (bus.swap_req) begin
          state_d = WAIT_SWAP;
        end else begin
          state_d = IDLE;
        end
      end
      BULK: begin
        back_d = (back_q & ~row_mask_s) | (row_mask_s & {NPIX{fill_q}});
        row_d  = row_q + RW'(1);
        if (row_q == RW'(ROWS - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = BULK;
        end
      end
      WAIT_SWAP: begin
        if (bus.frame_done) begin
          fb_d    = back_q;
          count_d = count_q + CW'(1);
          state_d = ACK;
        end else begin
          state_d = WAIT_SWAP;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and buffer registers; reset aborts any bulk fill or pending swap.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q <= IDLE;
      back_q  <= '0;
      fb_q    <= '0;
      count_q <= '0;
      row_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      back_q  <= back_d;
      fb_q    <= fb_d;
      count_q <= count_d;
      row_q   <= row_d;
      fill_q  <= fill_d;
    end
  end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed and randomized checks of frame_buffer_writer against a buffer-level reference model.
module tb_frame_buffer_writer;
  logic system_clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [63:0] mdl_back;
  logic [63:0] mdl_fb;
  int          mdl_cnt;

  frame_buffer_writer_if #(.ROWS(8), .COLS(8), .CW(8)) bus ();

  frame_buffer_writer #(.ROWS(8), .COLS(8), .CW(8)) dut (
    .system_clk (system_clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 system_clk = ~system_clk;

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] x, input logic [2:0] y, input logic d);
    int lowc;
    int badbusy;
    bus.wr_valid = 1'b1;
    bus.wr_op    = op;
    bus.wr_x     = x;
    bus.wr_y     = y;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
    case (op)
      2'b00: mdl_back[int'(y) * 8 + int'(x)] = d;
      2'b01: mdl_back[int'(y) * 8 + int'(x)] = ~mdl_back[int'(y) * 8 + int'(x)];
      2'b10: mdl_back = '0;
      default: mdl_back = '1;
    endcase
    if (op[1]) begin
      lowc    = 0;
      badbusy = 0;
      for (int i = 0; i < 20 && !bus.wr_ready; i++) begin
        if (!bus.busy) badbusy++;
        lowc++;
        step();
      end
      chk("bulk_ready_low_cycles", 64'(lowc), 64'd8);
      chk("bulk_busy_high", 64'(badbusy), 64'd0);
    end else begin
      chk("pixel_stays_idle", 64'(bus.wr_ready), 64'd1);
    end
  endtask

  task automatic swap(input int delay);
    int bad;
    bad = 0;
    bus.swap_req = 1'b1;
    step();
    chk("swap_enter_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < delay; i++) begin
      if (bus.swap_ack || bus.wr_ready || (bus.framebuffer !== mdl_fb)) bad++;
      step();
    end
    if (bus.swap_ack || bus.wr_ready || (bus.framebuffer !== mdl_fb)) bad++;
    chk("swap_wait_stable", 64'(bad), 64'd0);
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    mdl_fb  = mdl_back;
    mdl_cnt = (mdl_cnt + 1) % 256;
    chk("swap_ack_pulse", 64'(bus.swap_ack), 64'd1);
    chk("swap_framebuffer", bus.framebuffer, mdl_fb);
    chk("swap_frame_count", 64'(bus.frame_count), 64'(mdl_cnt));
    bus.swap_req = 1'b0;
    step();
    chk("swap_ack_drop", 64'(bus.swap_ack), 64'd0);
    chk("swap_back_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int bad;
    logic [1:0] op;
    rst            = 1'b1;
    bus.wr_valid   = 1'b0;
    bus.wr_op      = 2'b00;
    bus.wr_x       = 3'd0;
    bus.wr_y       = 3'd0;
    bus.wr_data    = 1'b0;
    bus.swap_req   = 1'b0;
    bus.frame_done = 1'b0;
    mdl_back = '0;
    mdl_fb   = '0;
    mdl_cnt  = 0;
    repeat (3) step();
    chk("reset_fb", bus.framebuffer, 64'd0);
    chk("reset_count", 64'(bus.frame_count), 64'd0);
    chk("reset_ack", 64'(bus.swap_ack), 64'd0);
    chk("reset_ready_low", 64'(bus.wr_ready), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_reset", 64'(bus.wr_ready), 64'd1);

    // single pixel then publish
    cmd(2'b00, 3'd3, 3'd2, 1'b1);
    swap(5);
    chk("pixel_frame_const", bus.framebuffer, 64'h0000_0000_0008_0000);
    chk("first_count", 64'(bus.frame_count), 64'd1);

    // fill, toggle corner, publish
    cmd(2'b11, 3'd0, 3'd0, 1'b0);
    cmd(2'b01, 3'd0, 3'd0, 1'b0);
    swap(2);
    chk("fill_toggle_const", bus.framebuffer, 64'hFFFF_FFFF_FFFF_FFFE);

    // long wait for frame_done
    cmd(2'b10, 3'd0, 3'd0, 1'b0);
    cmd(2'b00, 3'd7, 3'd7, 1'b1);
    swap(100);

    // command and swap_req together: command first, then swap
    bus.wr_valid = 1'b1;
    bus.wr_op    = 2'b00;
    bus.wr_x     = 3'd5;
    bus.wr_y     = 3'd1;
    bus.wr_data  = 1'b1;
    bus.swap_req = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    mdl_back[13] = 1'b1;
    chk("priority_still_idle", 64'(bus.busy), 64'd0);
    swap(3);
    chk("priority_pixel_published", 64'(bus.framebuffer[13]), 64'd1);

    // frame_done on the entry edge must not complete the swap
    cmd(2'b01, 3'd6, 3'd4, 1'b0);
    bus.swap_req   = 1'b1;
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("entry_fd_no_ack", 64'(bus.swap_ack), 64'd0);
    chk("entry_fd_waiting", 64'(bus.busy), 64'd1);
    chk("entry_fd_fb_held", bus.framebuffer, mdl_fb);
    swap(2);

    // reset while waiting, with coincident frame_done
    cmd(2'b11, 3'd0, 3'd0, 1'b0);
    bus.swap_req = 1'b1;
    step();
    rst            = 1'b1;
    bus.frame_done = 1'b1;
    step();
    chk("rst_wait_fb", bus.framebuffer, 64'd0);
    chk("rst_wait_count", 64'(bus.frame_count), 64'd0);
    chk("rst_wait_ack", 64'(bus.swap_ack), 64'd0);
    chk("rst_wait_ready_low", 64'(bus.wr_ready), 64'd0);
    rst            = 1'b0;
    bus.frame_done = 1'b0;
    bus.swap_req   = 1'b0;
    mdl_back = '0;
    mdl_fb   = '0;
    mdl_cnt  = 0;
    step();
    chk("rst_release_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_release_ack", 64'(bus.swap_ack), 64'd0);

    // 256 swaps without writes: identical frames, counter wraps
    cmd(2'b00, 3'd1, 3'd6, 1'b1);
    cmd(2'b00, 3'd4, 3'd0, 1'b1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      swap(0);
      if (bus.framebuffer !== 64'h0002_0000_0000_0010) bad++;
    end
    chk("wrap_frames_identical", 64'(bad), 64'd0);
    chk("wrap_count_zero", 64'(bus.frame_count), 64'd0);

    // randomized commands and swaps
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        op = 2'($urandom_range(0, 3));
        if (op[1] && ($urandom_range(0, 3) != 0)) op = 2'($urandom_range(0, 1));
        cmd(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end else begin
        swap(int'($urandom_range(0, 4)));
      end
    end
    swap(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
